mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one synchronous memory.
// Data wins contention until MAX_D_STREAK consecutive data grants have starved fetch.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        R_NONE,
        R_IF,
        R_D
    } resp_t;

    resp_t                state;
    resp_t                state_next;
    logic [STREAK_W-1:0]  streak;
    logic [STREAK_W-1:0]  streak_next;
    logic                 at_limit;

    always_comb begin
        at_limit = (streak == STREAK_MAX);
        d_gnt    = !reset && d_req && !(if_req && at_limit);
        if_gnt   = !reset && if_req && !d_gnt;
    end

    always_comb begin
        mem_enable = if_gnt | d_gnt;
        mem_we     = 1'b0;
        mem_addr   = if_addr;
        mem_wdata  = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Streak only measures how long fetch has been kept waiting.
    always_comb begin
        streak_next = streak;
        if (if_gnt || !if_req) begin
            streak_next = '0;
        end else if (d_gnt && !at_limit) begin
            streak_next = streak + STREAK_W'(1);
        end
    end

    always_comb begin
        state_next = R_NONE;
        if (if_gnt) begin
            state_next = R_IF;
        end else if (d_gnt && !d_we) begin
            state_next = R_D;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= R_NONE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // Gating with reset suppresses the response of a read granted just before reset.
    always_comb begin
        if_rvalid = (state == R_IF) && !reset;
        d_rvalid  = (state == R_D) && !reset;
        if_rdata  = mem_rdata;
        d_rdata   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: synchronous memory model plus a read-response
// scoreboard filled at grant time and drained when rvalid is due.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_enable;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    logic        mon_on;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    typedef struct {
        bit          is_if;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int checks;
    int passes;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: one-cycle read latency; preload port lets the bench seed contents.
    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_enable) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Response monitor: entries pushed in cycle k are due at the negedge of cycle k+1.
    always @(negedge clock) begin
        if (mon_on) begin
            exp_t e;
            bit   exp_if;
            bit   exp_d;
            exp_if = 1'b0;
            exp_d  = 1'b0;
            e.is_if = 1'b0;
            e.data  = '0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_if = e.is_if;
                exp_d  = !e.is_if;
            end
            checks++;
            if (if_rvalid !== exp_if)
                $display("[TB] FAIL if_rvalid @%0t: got %b expected %b", $time, if_rvalid, exp_if);
            else passes++;
            checks++;
            if (d_rvalid !== exp_d)
                $display("[TB] FAIL d_rvalid @%0t: got %b expected %b", $time, d_rvalid, exp_d);
            else passes++;
            if (exp_if) begin
                checks++;
                if (if_rdata !== e.data)
                    $display("[TB] FAIL if_rdata @%0t: got %h expected %h", $time, if_rdata, e.data);
                else passes++;
            end
            if (exp_d) begin
                checks++;
                if (d_rdata !== e.data)
                    $display("[TB] FAIL d_rdata @%0t: got %h expected %h", $time, d_rdata, e.data);
                else passes++;
            end
        end
    end

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd);
        @(posedge clock); #1;
        pl_en   = 1'b0;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        if_req = 1'b1; if_addr = 16'h0010;
        d_req  = 1'b1; d_we = 1'b1; d_addr = 16'h8000; d_wdata = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            checks++;
            if ({if_gnt, d_gnt, mem_enable, mem_we} !== 4'b0000)
                $display("[TB] FAIL reset_outputs: got %b expected 0000", {if_gnt, d_gnt, mem_enable, mem_we});
            else passes++;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        mon_on = 1'b1;
    endtask

    task automatic test_single_fetch();
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
        checks++;
        if ({if_gnt, d_gnt, mem_enable, mem_we} !== 4'b1010)
            $display("[TB] FAIL fetch_grant: got %b expected 1010", {if_gnt, d_gnt, mem_enable, mem_we});
        else passes++;
        checks++;
        if (mem_addr !== 16'h0010)
            $display("[TB] FAIL fetch_addr: got %h expected 0010", mem_addr);
        else passes++;
        sb.push_back('{1'b1, ref_mem[16'h0010]});
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
    endtask

    task automatic test_data_write_read();
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h8000, 16'h1234);
        @(negedge clock); #1;
        checks++;
        if ({if_gnt, d_gnt, mem_enable, mem_we} !== 4'b0111)
            $display("[TB] FAIL write_grant: got %b expected 0111", {if_gnt, d_gnt, mem_enable, mem_we});
        else passes++;
        checks++;
        if ({mem_addr, mem_wdata} !== {16'h8000, 16'h1234})
            $display("[TB] FAIL write_bus: got %h expected 80001234", {mem_addr, mem_wdata});
        else passes++;
        ref_mem[16'h8000] = 16'h1234;
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h8000, 16'h0);
        @(negedge clock); #1;
        checks++;
        if ({if_gnt, d_gnt, mem_enable, mem_we} !== 4'b0110)
            $display("[TB] FAIL read_grant: got %b expected 0110", {if_gnt, d_gnt, mem_enable, mem_we});
        else passes++;
        sb.push_back('{1'b0, ref_mem[16'h8000]});
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < 10; i++) begin
            bit          exp_i;
            logic [15:0] exp_a;
            drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h8000, 16'h0);
            @(negedge clock); #1;
            exp_i = (i % 5 == 4);
            exp_a = exp_i ? 16'h0010 : 16'h8000;
            checks++;
            if ({if_gnt, d_gnt} !== {exp_i, !exp_i})
                $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", i, {if_gnt, d_gnt}, {exp_i, !exp_i});
            else passes++;
            checks++;
            if (mem_addr !== exp_a)
                $display("[TB] FAIL contention_addr[%0d]: got %h expected %h", i, mem_addr, exp_a);
            else passes++;
            sb.push_back('{exp_i, ref_mem[exp_a]});
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 4; i++) begin
            preload(16'h0100 + 16'(i), 16'h1000 + 16'(i * 16'h0111));
            preload(16'h0200 + 16'(i), 16'hC000 + 16'(i * 16'h0123));
        end
        for (int i = 0; i < 8; i++) begin
            bit          is_i;
            logic [15:0] a;
            is_i = (i % 2 == 0);
            a = is_i ? (16'h0100 + 16'(i / 2)) : (16'h0200 + 16'(i / 2));
            drive(is_i, a, !is_i, 1'b0, a, 16'h0);
            @(negedge clock); #1;
            checks++;
            if ({if_gnt, d_gnt, mem_addr} !== {is_i, !is_i, a})
                $display("[TB] FAIL alt_grant[%0d]: got %b/%h expected %b/%h", i, {if_gnt, d_gnt}, mem_addr, {is_i, !is_i}, a);
            else passes++;
            sb.push_back('{is_i, ref_mem[a]});
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h8000, 16'h0);
        @(negedge clock); #1;
        checks++;
        if (d_gnt !== 1'b1)
            $display("[TB] FAIL midreset_grant: got %b expected 1", d_gnt);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h8000, 16'h0);
            reset = 1'b1;
            @(negedge clock); #1;
            checks++;
            if ({if_gnt, d_gnt, mem_enable, d_rvalid} !== 4'b0000)
                $display("[TB] FAIL midreset_quiet[%0d]: got %b expected 0000", i, {if_gnt, d_gnt, mem_enable, d_rvalid});
            else passes++;
        end
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h8000, 16'h0);
        reset = 1'b0;
        @(negedge clock); #1;
        checks++;
        if ({if_gnt, d_gnt} !== 2'b01)
            $display("[TB] FAIL post_reset_grant: got %b expected 01", {if_gnt, d_gnt});
        else passes++;
        sb.push_back('{1'b0, ref_mem[16'h8000]});
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        mon_on = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        reset = 1'b1;
        test_reset();
        preload(16'h0010, 16'hABCD);
        test_single_fetch();
        test_data_write_read();
        test_contention();
        test_alternating();
        test_reset_mid_read();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clock); #1;
        checks++;
        if (sb.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
